// File: rtl/count_tracker_pkg.sv
// count_tracker_pkg -- shared types and constants for the count_tracker block.
//   state_t : FSM state encoding (INIT, HOLD, UP, DOWN)
//   step_t  : classification of one cycle's step of the upstream counter
//   CNT_W   : width of the observed counter value
//   RUN_MAX : saturation value of the run-length counter
package count_tracker_pkg;

    localparam int CNT_W   = 4;
    localparam int RUN_MAX = 15;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        HOLD = 2'd1,
        UP   = 2'd2,
        DOWN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        STEP_UP   = 2'd0,
        STEP_DN   = 2'd1,
        STEP_HOLD = 2'd2,
        STEP_JUMP = 2'd3
    } step_t;

    // Destination state for a classified step once the FSM is past INIT.
    // A jump (load) is treated as a fresh hold.
    function automatic state_t step_to_state(input step_t s);
        case (s)
            STEP_UP: return UP;
            STEP_DN: return DOWN;
            default: return HOLD;
        endcase
    endfunction

endpackage

// File: rtl/count_tracker_if.sv
// count_tracker_if -- bundle of the count_tracker observation inputs and
// statistics outputs.
//   cnt_in, clr                : driven by the master (environment)
//   state, wrap_cnt, wrap_pulse,
//   jump_pulse, run_len,
//   min_val, max_val           : driven by the slave (count_tracker)
// WRAP_W must match the WRAP_W of the count_tracker attached to it.
interface count_tracker_if #(
    parameter int WRAP_W = 8
);
    import count_tracker_pkg::*;

    logic [CNT_W-1:0]  cnt_in;
    logic              clr;
    logic [1:0]        state;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              wrap_pulse;
    logic              jump_pulse;
    logic [CNT_W-1:0]  run_len;
    logic [CNT_W-1:0]  min_val;
    logic [CNT_W-1:0]  max_val;

    modport master (
        output cnt_in, clr,
        input  state, wrap_cnt, wrap_pulse, jump_pulse, run_len, min_val, max_val
    );

    modport slave (
        input  cnt_in, clr,
        output state, wrap_cnt, wrap_pulse, jump_pulse, run_len, min_val, max_val
    );

endinterface

// File: rtl/count_tracker_step_classifier.sv
// step_classifier -- purely combinational classification of one step of a
// 4-bit up/down counter.
//   prev   : value observed on the previous cycle
//   cnt_in : value observed this cycle
//   step   : STEP_UP (+1), STEP_DN (-1), STEP_HOLD (0) or STEP_JUMP (other)
//   wrap   : unit step across the 15/0 boundary in either direction
module step_classifier
    import count_tracker_pkg::*;
(
    input  logic [CNT_W-1:0] prev,
    input  logic [CNT_W-1:0] cnt_in,
    output step_t            step,
    output logic             wrap
);

    logic [CNT_W-1:0] diff;

    // Modular difference: +1 and -1 (all ones) come out right across the wrap.
    assign diff = cnt_in - prev;

    always_comb begin
        step = STEP_JUMP;
        wrap = 1'b0;
        if (diff == CNT_W'(1)) begin
            step = STEP_UP;
            wrap = (prev == '1) && (cnt_in == '0);
        end else if (diff == '1) begin
            step = STEP_DN;
            wrap = (prev == '0) && (cnt_in == '1);
        end else if (diff == '0) begin
            step = STEP_HOLD;
        end
    end

endmodule

// File: rtl/count_tracker.sv
// count_tracker -- watches a free-running 4-bit up/down counter and keeps
// statistics about its behaviour.
//   clk   : rising-edge clock, shared with the observed counter
//   rst_n : asynchronous active-low reset
//   bus   : count_tracker_if.slave -- cnt_in/clr in; state, wrap_cnt,
//           wrap_pulse, jump_pulse, run_len, min_val, max_val out
// All outputs are registered. Optional min/max tracking is enabled by
// defining COUNT_TRACKER_MINMAX_EN; otherwise min_val/max_val read as 0.
module count_tracker
    import count_tracker_pkg::*;
#(
    parameter int WRAP_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    count_tracker_if.slave  bus
);

    state_t            state_reg;
    logic [CNT_W-1:0]  prev_reg;
    logic [WRAP_W-1:0] wrap_cnt_reg;
    logic              wrap_pulse_reg;
    logic              jump_pulse_reg;
    logic [CNT_W-1:0]  run_len_reg;

    step_t             step;
    logic              wrap;
    state_t            state_next;
    logic [CNT_W-1:0]  run_len_next;

    step_classifier u_step_classifier (
        .prev   (prev_reg),
        .cnt_in (bus.cnt_in),
        .step   (step),
        .wrap   (wrap)
    );

    // Next state and run length for the tracking states (INIT handled in the FSM).
    always_comb begin
        state_next   = step_to_state(step);
        run_len_next = run_len_reg;
        if (state_next != state_reg) begin
            run_len_next = CNT_W'(1);
        end else if (run_len_reg != CNT_W'(RUN_MAX)) begin
            run_len_next = run_len_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= INIT;
            prev_reg       <= '0;
            wrap_cnt_reg   <= '0;
            wrap_pulse_reg <= 1'b0;
            jump_pulse_reg <= 1'b0;
            run_len_reg    <= '0;
        end else if (bus.clr) begin
            // clr overrides any step or wrap seen in the same cycle.
            state_reg      <= INIT;
            prev_reg       <= '0;
            wrap_cnt_reg   <= '0;
            wrap_pulse_reg <= 1'b0;
            jump_pulse_reg <= 1'b0;
            run_len_reg    <= '0;
        end else begin
            prev_reg       <= bus.cnt_in;
            wrap_pulse_reg <= 1'b0;
            jump_pulse_reg <= 1'b0;
            case (state_reg)
                INIT: begin
                    // First sample only seeds prev; nothing to classify yet.
                    state_reg   <= HOLD;
                    run_len_reg <= CNT_W'(1);
                end
                default: begin
                    state_reg      <= state_next;
                    run_len_reg    <= run_len_next;
                    jump_pulse_reg <= (step == STEP_JUMP);
                    if (wrap) begin
                        wrap_pulse_reg <= 1'b1;
                        if (wrap_cnt_reg != '1) begin
                            wrap_cnt_reg <= wrap_cnt_reg + WRAP_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.state      = state_reg;
    assign bus.wrap_cnt   = wrap_cnt_reg;
    assign bus.wrap_pulse = wrap_pulse_reg;
    assign bus.jump_pulse = jump_pulse_reg;
    assign bus.run_len    = run_len_reg;

`ifdef COUNT_TRACKER_MINMAX_EN
    logic [CNT_W-1:0] min_val_reg;
    logic [CNT_W-1:0] max_val_reg;

    // Extremes include the INIT capture; clr/reset return to the empty-set values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_val_reg <= '1;
            max_val_reg <= '0;
        end else if (bus.clr) begin
            min_val_reg <= '1;
            max_val_reg <= '0;
        end else begin
            if (bus.cnt_in < min_val_reg) begin
                min_val_reg <= bus.cnt_in;
            end
            if (bus.cnt_in > max_val_reg) begin
                max_val_reg <= bus.cnt_in;
            end
        end
    end

    assign bus.min_val = min_val_reg;
    assign bus.max_val = max_val_reg;
`else
    assign bus.min_val = '0;
    assign bus.max_val = '0;
`endif

endmodule
